dist_ram_be: RTL and testbench
==============================

// Module: dist_ram_be
// PURPOSE
//   Parametrised single-write / dual-read distributed RAM with per-byte write enables,
//   hardware clear-on-reset sequencer and optional registered second read port.
//   Successor to the fixed 1024x32 distributed RAM used as data memory in the lab CPU;
//   sits between the CPU datapath (sb/sh/sw via byte enables) and the debug/PDU read path.
// PARAMETERS
//   DATA_WIDTH  32  word width in bits; must be a multiple of 8
//   ADDR_WIDTH  10  address bits; DEPTH = 2**ADDR_WIDTH words
//   INIT_VAL    0   value written to every word by the clear sequencer
//   REG_OUT     0   0: dpo combinational from rd_addr; 1: dpo registered, 1-cycle latency
// PORTS
//   clk       in   1             clock, all state updates on rising edge
//   rst       in   1             asynchronous, active-high reset
//   clr       in   1             one-cycle pulse: re-run clear sequence
//   we        in   1             write request
//   be        in   DATA_WIDTH/8  byte-lane enables, bit i -> data[8i+7:8i]
//   addr      in   ADDR_WIDTH    write / primary read address
//   data      in   DATA_WIDTH    write data
//   rd_addr   in   ADDR_WIDTH    secondary read address
//   spo       out  DATA_WIDTH    combinational read of mem[addr]
//   dpo       out  DATA_WIDTH    read of mem[rd_addr] (see REG_OUT)
//   busy      out  1             1 while clear sequence runs
// BEHAVIOUR
//   FSM states: INIT, RUN. Counter init_cnt[ADDR_WIDTH-1:0].
//   - rst asserted (any time, incl. mid-INIT): state<=INIT, init_cnt<=0, dpo reg<=0.
//     Array contents are not reset asynchronously; only the sequencer clears them.
//   - INIT: each rising edge writes INIT_VAL to mem[init_cnt], init_cnt++;
//     on the edge with init_cnt==DEPTH-1 the last word is written and state<=RUN.
//     busy=1 exactly for DEPTH rising edges after rst release; busy=(state==INIT).
//   - RUN: on rising edge with we=1 and clr=0, for each i with be[i]=1:
//     mem[addr][8i+:8]<=data[8i+:8]; lanes with be[i]=0 keep old value. be=0 -> no-op.
//   - clr=1 in RUN: state<=INIT, init_cnt<=0 next edge; a same-cycle write is dropped.
//     clr in INIT ignored (sequence continues, not restarted).
//   - we during INIT ignored entirely; no queuing.
//   Read ports:
//   - spo = (state==RUN) ? mem[addr] : 0, combinational. Write to addr shows new value
//     only after the write edge (no bypass).
//   - REG_OUT=0: dpo = (state==RUN) ? mem[rd_addr] : 0, combinational.
//   - REG_OUT=1: dpo <= (state==RUN) ? mem[rd_addr] : 0 each edge; read-first: if the
//     same edge writes rd_addr, dpo gets the old word, new word one edge later.
//   Reset values: busy=1, spo=0, dpo=0 (both modes) while in INIT.
//   Address wrap: addresses are exactly ADDR_WIDTH bits; no out-of-range case exists.
//   init_cnt wraps to 0 on INIT exit; unused in RUN.
// TESTING (run with ADDR_WIDTH=4, DATA_WIDTH=32 unless stated)
//   1. rst pulse, release -> busy=1 for exactly 16 edges, then 0; sweep addr/rd_addr
//      0..15 -> spo=dpo=0x00000000 (INIT_VAL=0); repeat with INIT_VAL=0xA5A5A5A5.
//   2. RUN: we=1 be=4'b1111 addr=3 data=0xDEADBEEF -> spo@3=0xDEADBEEF after edge;
//      then be=4'b0010 data=0x00001200 -> 0xDEAD12EF; be=4'b0000 -> unchanged.
//   3. we=1 addr=5 data=0x12345678 during busy -> ignored; after INIT spo@5=0.
//   4. REG_OUT=1, mem[7]=0x11111111, write 0x22222222 to 7 with rd_addr=7 ->
//      dpo=0x11111111 after that edge, 0x22222222 after the next.
//   5. rst re-asserted after 7 INIT edges -> sequence restarts, busy high 16 more edges,
//      dpo=0 throughout; all words = INIT_VAL afterwards.
//   6. RUN with data written at 0..15, clr=1 and we=1 addr=2 same cycle -> write
//      dropped, busy 16 edges, then all words = INIT_VAL; clr pulsed mid-INIT -> no extension.

Source files
------------

// File: rtl/dist_ram_be.sv
// Single-write / dual-read distributed RAM with byte enables, a clear-on-reset
// sequencer that walks every word to INIT_VAL, and an optionally registered dpo port.
module dist_ram_be #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0,
    parameter bit                    REG_OUT    = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   spo,
    output logic [DATA_WIDTH-1:0]   dpo,
    output logic                    busy
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {INIT, RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    run;

    assign run  = (state_q == RUN);
    assign busy = ~run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // init_cnt wraps to 0 naturally on the last INIT edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = RUN;
            end
            RUN: begin
                if (clr) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Storage has no reset: contents are only ever cleared by the sequencer.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem_q[cnt_q] <= INIT_VAL;
        end else if (we && !clr) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem_q[addr][8*i +: 8] <= data[8*i +: 8];
            end
        end
    end

    assign spo = run ? mem_q[addr] : '0;

    generate
        if (REG_OUT) begin : g_reg_out
            logic [DATA_WIDTH-1:0] dpo_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) dpo_q <= '0;
                else     dpo_q <= run ? mem_q[rd_addr] : '0;
            end
            // The word captured on the clr edge must not leak out while clearing.
            assign dpo = run ? dpo_q : '0;
        end else begin : g_comb_out
            assign dpo = run ? mem_q[rd_addr] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_dist_ram_be.sv
// Bench for dist_ram_be: two instances (combinational dpo / INIT_VAL=0 and
// registered dpo / INIT_VAL=A5A5A5A5) share one directed stimulus stream.
module tb_dist_ram_be;
    localparam int          AW  = 4;
    localparam int          DW  = 32;
    localparam int          D   = 16;
    localparam logic [31:0] IV1 = 32'hA5A5A5A5;

    logic        clk = 1'b0, rst = 1'b1, clr = 1'b0, we = 1'b0;
    logic [3:0]  be = '0;
    logic [AW-1:0] addr = '0, rd_addr = '0;
    logic [DW-1:0] data = '0;
    logic [DW-1:0] spo0, dpo0, spo1, dpo1;
    logic        busy0, busy1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    dist_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VAL(32'h0), .REG_OUT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .be(be), .addr(addr), .data(data),
        .rd_addr(rd_addr), .spo(spo0), .dpo(dpo0), .busy(busy0));

    dist_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VAL(IV1), .REG_OUT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .be(be), .addr(addr), .data(data),
        .rd_addr(rd_addr), .spo(spo1), .dpo(dpo1), .busy(busy1));

    always #5 clk = ~clk;

    // Model: word arrays plus "edges of clearing left"; contents become INIT_VAL
    // as a whole when the clear finishes (they are invisible while clearing).
    logic [31:0] m0 [D];
    logic [31:0] m1 [D];
    int          left = D;
    logic [31:0] r1 = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            left = D;
            r1   = '0;
        end else begin
            r1 = (left > 0) ? 32'h0 : m1[rd_addr];
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    for (int i = 0; i < D; i++) begin
                        m0[i] = 32'h0;
                        m1[i] = IV1;
                    end
                end
            end else if (clr) begin
                left = D;
            end else if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        m0[addr][8*b +: 8] = data[8*b +: 8];
                        m1[addr][8*b +: 8] = data[8*b +: 8];
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy0", {31'b0, busy0}, {31'b0, left > 0});
            chk("busy1", {31'b0, busy1}, {31'b0, left > 0});
            chk("spo0",  spo0, (left > 0) ? 32'h0 : m0[addr]);
            chk("spo1",  spo1, (left > 0) ? 32'h0 : m1[addr]);
            chk("dpo0",  dpo0, (left > 0) ? 32'h0 : m0[rd_addr]);
            chk("dpo1",  dpo1, (left > 0) ? 32'h0 : r1);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Counts edges until busy drops; optionally pulses clr at edge index pulse_at.
    task automatic wait_busy(input int pulse_at, output int n);
        n = 0;
        while (busy0 && n < 100) begin
            clr = (n == pulse_at);
            tick();
            n++;
        end
        clr = 1'b0;
    endtask

    task automatic sweep(input string nm);
        for (int i = 0; i < D; i++) begin
            addr    = AW'(i);
            rd_addr = AW'(i);
            tick();
            chk({nm, "_spo0"}, spo0, 32'h0);
            chk({nm, "_dpo0"}, dpo0, 32'h0);
            chk({nm, "_spo1"}, spo1, IV1);
            chk({nm, "_dpo1"}, dpo1, IV1);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
        addr = a; be = b; data = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    initial begin
        int n;
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_busy", {31'b0, busy0}, 32'h1);
        chk("rst_spo1", spo1, 32'h0);
        chk("rst_dpo1", dpo1, 32'h0);
        rst = 1'b0;

        // 1: busy length after release, then every word reads INIT_VAL
        wait_busy(-1, n);
        chk("busy_len1", 32'(n), 32'd16);
        sweep("init1");

        // 2: full write, single-lane merge, empty byte mask
        wr(4'd3, 4'b1111, 32'hDEADBEEF);
        chk("wr_full0", spo0, 32'hDEADBEEF);
        chk("wr_full1", spo1, 32'hDEADBEEF);
        wr(4'd3, 4'b0010, 32'h00001200);
        chk("wr_lane0", spo0, 32'hDEAD12EF);
        chk("wr_lane1", spo1, 32'hDEAD12EF);
        wr(4'd3, 4'b0000, 32'hFFFFFFFF);
        chk("wr_none0", spo0, 32'hDEAD12EF);

        // 3: writes while clearing are dropped
        rst = 1'b1;
        tick();
        rst = 1'b0;
        addr = 4'd5; be = 4'hF; data = 32'h12345678; we = 1'b1;
        tick(); tick(); tick();
        we = 1'b0;
        wait_busy(-1, n);
        chk("busy_len3", 32'(n), 32'd13);
        addr = 4'd5;
        #1;
        chk("busy_wr0", spo0, 32'h0);
        chk("busy_wr1", spo1, IV1);

        // 4: registered dpo is read-first on a same-address write
        rd_addr = 4'd7;
        addr = 4'd7; be = 4'hF; data = 32'h11111111; we = 1'b1;
        tick();
        chk("rf_old1", dpo1, IV1);
        chk("rf_comb0", dpo0, 32'h11111111);
        data = 32'h22222222;
        tick();
        chk("rf_mid1", dpo1, 32'h11111111);
        we = 1'b0;
        tick();
        chk("rf_new1", dpo1, 32'h22222222);

        // 5: reset re-asserted part-way through clearing restarts it
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("mid_busy", {31'b0, busy1}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_busy(-1, n);
        chk("busy_len5", 32'(n), 32'd16);
        sweep("init5");

        // 6: clr drops a same-cycle write; clr while clearing does not extend it
        for (int i = 0; i < D; i++) wr(AW'(i), 4'hF, {4{8'(i * 17 + 3)}});
        addr = 4'd2;
        #1;
        chk("pre_clr0", spo0, 32'h25252525);
        clr = 1'b1; we = 1'b1; addr = 4'd2; be = 4'hF; data = 32'hFFFFFFFF;
        tick();
        clr = 1'b0; we = 1'b0;
        chk("clr_busy", {31'b0, busy0}, 32'h1);
        wait_busy(5, n);
        chk("busy_len6", 32'(n), 32'd16);
        sweep("init6");

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
